// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: state encoding and default vectors for the fetch sequencer
package pc_fetch_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;
    localparam logic [31:0] INSTR_BYTES  = 32'd4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0080;
endpackage

// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq: PC sequencer with one outstanding imem fetch; PC_MISALIGN_TRAP_EN traps misaligned redirects
module pc_fetch_seq
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_PC  = DEF_TRAP_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] pc_plus_4,
    output logic        misalign_err
);
    state_t      state, state_d;
    logic [31:0] pc, pc_d, pend_pc, pend_pc_d, addr_d, if_pc_d, if_instr_d, pp4_d, tgt;
    logic        pend, pend_d, req_d, valid_d, mis;
`ifdef PC_MISALIGN_TRAP_EN
    assign mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign tgt = mis ? TRAP_PC : (redirect_pc & ~32'h3);
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        pend_d     = pend;
        pend_pc_d  = pend_pc;
        req_d      = imem_req;
        addr_d     = imem_addr;
        valid_d    = if_valid;
        if_pc_d    = if_pc;
        if_instr_d = if_instr;
        pp4_d      = pc_plus_4;
        case (state)
            S_IDLE: begin
                state_d = S_FETCH;
                pc_d    = redirect_valid ? tgt : pc;
            end
            S_FETCH: begin
                // req=0 here is the bubble before (re)issuing; the address is still free to change
                if (!imem_req) begin
                    pc_d   = redirect_valid ? tgt : pc;
                    addr_d = pc_d;
                    req_d  = 1'b1;
                end else if (imem_ack) begin
                    req_d = 1'b0;
                    if (redirect_valid || pend) begin
                        pc_d   = redirect_valid ? tgt : pend_pc;
                        pend_d = 1'b0;
                    end else begin
                        valid_d    = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = imem_addr;
                        pp4_d      = imem_addr + INSTR_BYTES;
                        state_d    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pend_d    = 1'b1;
                    pend_pc_d = tgt;
                end
            end
            S_HOLD: begin
                if (redirect_valid || if_ready) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_valid ? tgt : pc_plus_4;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            pend         <= 1'b0;
            pend_pc      <= '0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_instr     <= '0;
            pc_plus_4    <= INSTR_BYTES;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            pend         <= pend_d;
            pend_pc      <= pend_pc_d;
            imem_req     <= req_d;
            imem_addr    <= addr_d;
            if_valid     <= valid_d;
            if_pc        <= if_pc_d;
            if_instr     <= if_instr_d;
            pc_plus_4    <= pp4_d;
            misalign_err <= mis;
        end
    end
endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb_pc_fetch_seq: vector table, directed redirect/reset sequences and a randomized transaction-level check
module tb_pc_fetch_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc, if_instr, pc_plus_4;
    logic        misalign_err;

    pc_fetch_seq dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr),
        .pc_plus_4(pc_plus_4), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        ack;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[19];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic logic [31:0] tgt(input logic [31:0] r);
        return (MIS && r[1:0] != 2'b00) ? 32'h0000_0080 : {r[31:2], 2'b00};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic v_rv, input logic [31:0] v_rpc, input logic v_ack, input logic v_rdy);
        redirect_valid = v_rv;
        redirect_pc    = v_rpc;
        imem_ack       = v_ack;
        imem_rdata     = mem(imem_addr);
        if_ready       = v_rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic wait_req(input string nm, input logic [31:0] exp);
        int k = 0;
        while (!imem_req && k < 20) begin
            cyc(0, 0, 0, 0);
            k++;
        end
        chk(nm, imem_req ? imem_addr : 32'hDEAD_DEAD, exp);
    endtask

    task automatic fetch_one(input string nm, input logic [31:0] a);
        wait_req(nm, a);
        cyc(0, 0, 1, 0);
        chk({nm, " valid"}, 32'(if_valid), 1);
        chk({nm, " pc"}, if_pc, a);
        chk({nm, " instr"}, if_instr, mem(a));
        chk({nm, " pp4"}, pc_plus_4, a + 32'd4);
    endtask

    logic        r_rv, r_ack, r_rdy, p_req, p_ack, p_v, p_cons, exp_mis;
    logic [31:0] r_rpc, exp_pc, p_addr, p_pc, p_instr;
    int          lat, n_del;

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0, 0,  0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0,  0, 0};
        tbl[2]  = '{0, 0, 0, 0, 1, 0,  0, 0};
        tbl[3]  = '{0, 0, 1, 1, 1, 0,  0, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 0,  1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0,  0, 0};
        tbl[6]  = '{0, 0, 1, 0, 1, 4,  0, 0};
        for (int i = 7; i < 12; i++) tbl[i] = '{0, 0, 0, 0, 0, 0, 1, 4};
        tbl[12] = '{0, 0, 0, 1, 0, 0,  1, 4};
        tbl[13] = '{0, 0, 0, 0, 0, 0,  0, 0};
        tbl[14] = '{0, 0, 0, 0, 1, 8,  0, 0};
        tbl[15] = '{0, 0, 1, 1, 1, 8,  0, 0};
        tbl[16] = '{0, 0, 0, 1, 0, 0,  1, 8};
        tbl[17] = '{0, 0, 0, 0, 0, 0,  0, 0};
        tbl[18] = '{0, 0, 0, 0, 1, 12, 0, 0};

        @(negedge clk);
        do_reset();
        chk("rst req", 32'(imem_req), 0);
        chk("rst addr", imem_addr, 0);
        chk("rst valid", 32'(if_valid), 0);
        chk("rst if_pc", if_pc, 0);
        chk("rst instr", if_instr, 0);
        chk("rst pp4", pc_plus_4, 32'h4);
        chk("rst misalign", 32'(misalign_err), 0);

        for (int i = 0; i < 19; i++) begin
            chk($sformatf("tbl%0d req", i), 32'(imem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("tbl%0d addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d valid", i), 32'(if_valid), 32'(tbl[i].e_v));
            if (tbl[i].e_v) begin
                chk($sformatf("tbl%0d pc", i), if_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d instr", i), if_instr, mem(tbl[i].e_pc));
                chk($sformatf("tbl%0d pp4", i), pc_plus_4, tbl[i].e_pc + 32'd4);
            end
            cyc(tbl[i].rv, tbl[i].rpc, tbl[i].ack, tbl[i].rdy);
        end

        // redirect while the fetch at 0x8 is waiting on a late ack
        do_reset();
        fetch_one("late f0", 0);
        cyc(0, 0, 0, 1);
        fetch_one("late f4", 4);
        cyc(0, 0, 0, 1);
        wait_req("late req8", 8);
        cyc(1, 32'h100, 0, 0);
        chk("late addr hold1", imem_req ? imem_addr : 32'hDEAD_DEAD, 8);
        cyc(0, 0, 0, 0);
        chk("late addr hold2", imem_req ? imem_addr : 32'hDEAD_DEAD, 8);
        cyc(0, 0, 0, 0);
        chk("late addr hold3", imem_req ? imem_addr : 32'hDEAD_DEAD, 8);
        cyc(0, 0, 1, 0);
        chk("late dropped", 32'(if_valid), 0);
        wait_req("late target", 32'h100);

        // two redirects while one fetch is outstanding: the last one wins
        cyc(1, 32'h200, 0, 0);
        cyc(1, 32'h300, 0, 0);
        cyc(0, 0, 1, 0);
        chk("double dropped", 32'(if_valid), 0);
        wait_req("double last wins", 32'h300);

        // redirect in hold with a simultaneous handshake, then wrap past the top
        cyc(0, 0, 1, 0);
        chk("hold valid", 32'(if_valid), 1);
        chk("hold pc", if_pc, 32'h300);
        cyc(1, 32'hFFFF_FFFC, 0, 1);
        chk("hold redirect drop", 32'(if_valid), 0);
        fetch_one("wrap top", 32'hFFFF_FFFC);
        cyc(0, 0, 0, 1);
        wait_req("wrap zero", 0);

        // misaligned redirect
        cyc(1, 32'h102, 0, 0);
        chk("mis pulse", 32'(misalign_err), 32'(MIS));
        cyc(0, 0, 1, 0);
        chk("mis one cycle", 32'(misalign_err), 0);
        wait_req("mis target", MIS ? 32'h80 : 32'h100);

        // reset mid-fetch; stray acks while req=0 must be ignored
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        chk("midrst req", 32'(imem_req), 0);
        cyc(0, 0, 1, 1);
        chk("stray ack idle", 32'(if_valid), 0);
        cyc(0, 0, 1, 0);
        chk("stray ack bubble", 32'(if_valid), 0);
        wait_req("midrst restart", 0);

        // randomized run against a transaction-level model
        do_reset();
        exp_pc = 32'h0;
        p_req = 0; p_ack = 0; p_v = 0; p_cons = 0; exp_mis = 0;
        p_addr = 0; p_pc = 0; p_instr = 0;
        lat = -1;
        n_del = 0;
        for (int c = 0; c < 3000; c++) begin
            if (p_req && !p_ack) chk("rnd addr stable", imem_req ? imem_addr : 32'hDEAD_DEAD, p_addr);
            if (p_v && !p_cons) begin
                chk("rnd hold valid", 32'(if_valid), 1);
                chk("rnd hold pc", if_pc, p_pc);
                chk("rnd hold instr", if_instr, p_instr);
            end else if (if_valid) begin
                chk("rnd pc", if_pc, exp_pc);
                chk("rnd instr", if_instr, mem(if_pc));
                n_del++;
            end
            if (if_valid) begin
                chk("rnd pp4", pc_plus_4, if_pc + 32'd4);
                chk("rnd req low", 32'(imem_req), 0);
            end
            chk("rnd misalign", 32'(misalign_err), 32'(exp_mis));
            r_rv  = ($urandom_range(0, 9) == 0);
            r_rpc = $urandom;
            r_rdy = ($urandom_range(0, 2) != 0);
            if (imem_req) begin
                if (lat < 0) lat = $urandom_range(0, 3);
                r_ack = (lat == 0);
                lat   = (lat == 0) ? -1 : lat - 1;
            end else begin
                lat   = -1;
                r_ack = ($urandom_range(0, 7) == 0);
            end
            p_req   = imem_req;
            p_ack   = r_ack;
            p_addr  = imem_addr;
            p_v     = if_valid;
            p_cons  = r_rv || r_rdy;
            p_pc    = if_pc;
            p_instr = if_instr;
            exp_mis = MIS && r_rv && (r_rpc[1:0] != 2'b00);
            if (r_rv) exp_pc = tgt(r_rpc);
            else if (if_valid && r_rdy) exp_pc = if_pc + 32'd4;
            cyc(r_rv, r_rpc, r_ack, r_rdy);
        end
        chk("rnd deliveries", 32'(n_del >= 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
